// File: rtl/dispatcher.sv
// dispatcher: miniGPU block scheduler.
// Latches the kernel thread count on start, splits it into THREADS_PER_BLOCK
// sized blocks, hands one block per cycle to the lowest-index idle core and
// raises done once every block has completed.
// Optional feature macro: DISPATCHER_CYCLE_COUNT_EN enables the kernel cycle
// counter on cycle_count; without it cycle_count is tied to zero.
module dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             thread_count,
  input  logic [NUM_CORES-1:0]   core_done,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [NUM_CORES-1:0]   core_reset,
  output logic [NUM_CORES*8-1:0] core_block_id,
  output logic [NUM_CORES*8-1:0] core_thread_count,
  output logic                   done,
  output logic [15:0]            cycle_count
);

  localparam int         SHIFT = $clog2(THREADS_PER_BLOCK);
  localparam logic [8:0] TPB9  = 9'(THREADS_PER_BLOCK);
  localparam logic [15:0] TPB16 = 16'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DISPATCH,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]           tc_q;
  logic [8:0]           total_blocks_q;
  logic [8:0]           blocks_dispatched_q;
  logic [8:0]           blocks_done_q;
  logic [8:0]           total_blocks_calc;
  logic [NUM_CORES-1:0] complete;
  logic [NUM_CORES-1:0] grant;
  logic [8:0]           complete_count;
  logic [15:0]          remaining;
  logic [7:0]           grant_count;
  logic [7:0]           block_id_q [NUM_CORES];
  logic [7:0]           thread_q   [NUM_CORES];

  // Block count rounds up; 9 bits hold 255 + 127 without overflow.
  assign total_blocks_calc = ({1'b0, tc_q} + TPB9 - 9'd1) >> SHIFT;

  // Valid threads in the block about to be handed out (last block may be short).
  assign remaining   = 16'(tc_q) - (16'(blocks_dispatched_q) << SHIFT);
  assign grant_count = (remaining > TPB16) ? 8'(THREADS_PER_BLOCK) : remaining[7:0];

  assign done = (state_q == DONE);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: state_d is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = LOAD;
      LOAD:     state_d = (total_blocks_calc == 9'd0) ? DONE : DISPATCH;
      DISPATCH: if (blocks_done_q == total_blocks_q) state_d = DONE;
      DONE:     if (!start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Completion detection and lowest-index free-core selection.
  always_comb begin
    complete       = '0;
    grant          = '0;
    complete_count = '0;
    if (state_q == DISPATCH) begin
      // core_done is only meaningful while the core holds a block.
      complete = core_done & core_start;
      for (int i = 0; i < NUM_CORES; i++) begin
        complete_count = complete_count + 9'(complete[i]);
      end
      if (blocks_dispatched_q < total_blocks_q) begin
        // Scan downward so the last (lowest-index) free core wins.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
          if (!core_start[i] && !core_reset[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
          end
        end
      end
    end
  end

  // Kernel bookkeeping and per-core block assignment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tc_q                <= '0;
      total_blocks_q      <= '0;
      blocks_dispatched_q <= '0;
      blocks_done_q       <= '0;
      core_start          <= '0;
      core_reset          <= '0;
      // NOTE: these arrays are per-core flops, not RAM, so they are reset to keep outputs at 0.
      for (int i = 0; i < NUM_CORES; i++) begin
        block_id_q[i] <= '0;
        thread_q[i]   <= '0;
      end
    end else begin
      // One-cycle reset pulse to every core that just finished.
      core_reset <= complete;

      if (state_q == IDLE && start) tc_q <= thread_count;

      if (state_q == LOAD) begin
        total_blocks_q      <= total_blocks_calc;
        blocks_dispatched_q <= '0;
        blocks_done_q       <= '0;
      end

      if (state_q == DISPATCH) begin
        blocks_done_q <= blocks_done_q + complete_count;
        if (|grant) blocks_dispatched_q <= blocks_dispatched_q + 9'd1;
      end

      // grant only targets idle cores, so it never collides with complete.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (complete[i]) begin
          core_start[i] <= 1'b0;
        end else if (grant[i]) begin
          core_start[i] <= 1'b1;
          block_id_q[i] <= blocks_dispatched_q[7:0];
          thread_q[i]   <= grant_count;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
    assign core_block_id[8*g +: 8]     = block_id_q[g];
    assign core_thread_count[8*g +: 8] = thread_q[g];
  end

`ifdef DISPATCHER_CYCLE_COUNT_EN
  logic [15:0] cycle_q;

  // Kernel cycle counter: cleared in LOAD, saturating count in DISPATCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= '0;
    end else if (state_q == LOAD) begin
      cycle_q <= '0;
    end else if (state_q == DISPATCH && cycle_q != 16'hFFFF) begin
      cycle_q <= cycle_q + 16'd1;
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = 16'h0000;
`endif

endmodule

// File: doc/dispatcher.md
# dispatcher

Block scheduler of the miniGPU, directly downstream of the device control register. On `start` it latches the kernel's total thread count and splits it into fixed-size blocks. It hands those blocks one at a time to idle compute cores and counts block completions. It raises `done` once every block has finished.

## Interface
- `NUM_CORES`, default 2: number of compute cores driven; range 1–8.
- `THREADS_PER_BLOCK`, default 4: threads per block; power of two, range 1–128.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: kernel launch request; level-sensitive and sampled in IDLE only.
- `thread_count` input 8: total threads from the device control register.
- `core_done` input NUM_CORES: per-core block-finished flag; level.
- `core_start` output NUM_CORES: per-core run request; held high while a block is assigned.
- `core_reset` output NUM_CORES: per-core one-cycle reset pulse after a block completes.
- `core_block_id` output NUM_CORES*8: per-core block index; core i uses bits [8i+7:8i].
- `core_thread_count` output NUM_CORES*8: per-core number of valid threads in its block.
- `done` output 1: kernel complete; held until `start` is low.
- `cycle_count` output 16: kernel cycle count (see Configuration).

## Operation
- **Reset:** all outputs are 0, FSM is in IDLE, and all counters are 0.
- **FSM states:** IDLE, LOAD, DISPATCH, DONE.
- **IDLE:**
  - Latches `thread_count` into `tc_q` when `start`=1.
  - Transitions to LOAD.
- **LOAD:**
  - Computes `total_blocks` = (tc_q + THREADS_PER_BLOCK − 1) >> log2(THREADS_PER_BLOCK), using 9-bit intermediate arithmetic.
  - Clears `blocks_dispatched` and `blocks_done`.
  - Goes to DONE if `total_blocks`==0; otherwise goes to DISPATCH.
- **DISPATCH, assignment:**
  - Each cycle, if `blocks_dispatched` < `total_blocks`, the lowest-index free core is assigned.
  - A core is free when its `core_start`=0 and its `core_reset`=0.
  - The assigned core gets `core_block_id` = `blocks_dispatched` and `core_start`=1.
  - It gets `core_thread_count` = min(THREADS_PER_BLOCK, tc_q − block_id·THREADS_PER_BLOCK).
  - `blocks_dispatched` then increments. At most one assignment is made per cycle.
- **DISPATCH, completion:**
  - When `core_done[i]`=1 while `core_start[i]`=1, the block is complete.
  - On completion, `core_start[i]` clears, `core_reset[i]` is set for exactly one cycle, and `blocks_done` increments.
  - Simultaneous completions add their popcount to `blocks_done`.
  - `core_done` sampled while `core_start[i]`=0 is ignored.
  - Completion on one core and assignment to a different core may occur in the same cycle.
- **DISPATCH exit:** the FSM moves to DONE when `blocks_done` == `total_blocks`.
- **DONE:**
  - `done`=1.
  - Returns to IDLE when `start`=0; `done` clears on that edge.
- **Start while busy:** `start` is ignored outside IDLE, and `thread_count` changes after the latch have no effect.
- **Reset mid-kernel:** asserting `reset_n` during a kernel returns the block to reset state immediately. The partial kernel is abandoned with no `done`.

## Timing
- Edge E0 samples `start`=1. The FSM is in LOAD after E0 and in DISPATCH after E1.
- `core_start[0]` is high after E2, i.e. 2 cycles after `start` is sampled.
- With N ≥ 2 free cores, `core_start[k]` rises after edge E2+k.
- `core_done[i]` high at edge Ec gives `core_start[i]`=0 and `core_reset[i]`=1 after Ec, and `core_reset[i]`=0 after Ec+1.
  - Core i can be reassigned at Ec+2 at the earliest.
- The last completion at edge Ec gives `done`=1 after Ec+1.
- With `thread_count`=0, `done`=1 after E1, one cycle after LOAD.
- `core_block_id` and `core_thread_count` are stable for the entire time `core_start[i]`=1.

## Configuration
- `DISPATCHER_CYCLE_COUNT_EN` defined:
  - `cycle_count` clears in LOAD and increments every cycle in DISPATCH.
  - It saturates at 16'hFFFF and holds its value in DONE and IDLE until the next LOAD.
- `DISPATCHER_CYCLE_COUNT_EN` undefined: `cycle_count` is tied to 16'h0000 and no counter logic is synthesised.

## Test plan
- **Even split:** `thread_count`=8, 2 cores, THREADS_PER_BLOCK=4, `start`.
  - Core0 gets block 0 (count 4) after E2; core1 gets block 1 (count 4) after E3.
  - Completing both gives `done` one cycle after the last completion.
- **Partial last block:** `thread_count`=10.
  - 3 blocks, the third with `core_thread_count`=2.
  - The third block goes to the first core freed (after its `core_reset` pulse), and `done` asserts only after 3 completions.
- **Zero threads:** `thread_count`=0, `start`.
  - `done`=1 after E1 and `core_start` stays 0.
  - Dropping `start` clears `done` and returns to IDLE.
- **Simultaneous completion:** with both cores running, raise `core_done`=2'b11 in the same cycle.
  - `blocks_done` advances by 2, both `core_reset` bits pulse for one cycle, and the next blocks go to core0 then core1 on consecutive edges.
- **Reset and relaunch:**
  - Changing `thread_count` and re-pulsing `start` mid-kernel has no effect.
  - Asserting `reset_n`=0 mid-kernel clears all outputs asynchronously.
  - A relaunch after release runs normally.
- **Cycle counter:** with the macro defined, `thread_count`=4 and `core_done` returned 5 cycles after `core_start` give a deterministic `cycle_count` value that holds through DONE.
  - With the macro undefined, `cycle_count`=0 throughout.
